// File: rtl/sequence_generator_pkg.sv
// Shared types and constants for the serial sequence generator.
// The LFSR constants are only consumed when SEQUENCE_GENERATOR_LFSR_EN is defined.
package sequence_generator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1 expressed as a tap mask over state bits 7..0.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/sequence_generator_lfsr8.sv
// 8-bit Fibonacci LFSR that steps only when advance is high.
// Reset loads LFSR_SEED; there is no other reseed path.
module lfsr8
    import sequence_generator_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    output logic [7:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LFSR_SEED;
        end else if (advance) begin
            state <= {state[6:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, reps times, with gap bits between.
// Define SEQUENCE_GENERATOR_LFSR_EN to fill gaps from an 8-bit LFSR instead of constant zero.
module sequence_generator
    import sequence_generator_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int REP_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             out_seq,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    state_t             state_reg;
    logic [PAT_W-1:0]   pattern_reg;
    logic [REP_W-1:0]   rep_reg;
    logic [GAP_W-1:0]   gap_reg;
    logic [GAP_W-1:0]   gap_cnt_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               filler_bit;

`ifdef SEQUENCE_GENERATOR_LFSR_EN
    logic [7:0] lfsr_state;
    logic       lfsr_advance;

    // Step exactly when the next registered output bit is a gap bit, so each gap
    // bit consumes one fresh LFSR value starting from the current state.
    assign lfsr_advance = !abort &&
        (((state_reg == SEND) && (idx_reg == '0) && (rep_reg != REP_W'(1)) && (gap_reg != '0)) ||
         ((state_reg == GAP) && (gap_cnt_reg != GAP_W'(1))));

    lfsr8 u_lfsr8 (
        .clk     (clk),
        .rst     (rst),
        .advance (lfsr_advance),
        .state   (lfsr_state)
    );

    assign filler_bit = lfsr_state[0];
`else
    assign filler_bit = 1'b0;
`endif

    // Registers describe the bit currently on out_seq; idx_reg is that bit's position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            pattern_reg <= '0;
            rep_reg     <= '0;
            gap_reg     <= '0;
            gap_cnt_reg <= '0;
            idx_reg     <= '0;
            out_seq     <= 1'b0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done        <= 1'b0;
            frame_start <= 1'b0;
            if (abort) begin
                state_reg <= IDLE;
                out_seq   <= 1'b0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        out_seq   <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        if (start) begin
                            pattern_reg <= pattern;
                            rep_reg     <= reps;
                            gap_reg     <= gap;
                            if (reps == '0) begin
                                done <= 1'b1;
                            end else begin
                                state_reg   <= SEND;
                                idx_reg     <= IDX_MSB;
                                out_seq     <= pattern[PAT_W-1];
                                out_valid   <= 1'b1;
                                frame_start <= 1'b1;
                                busy        <= 1'b1;
                            end
                        end
                    end
                    SEND: begin
                        if (idx_reg != '0) begin
                            idx_reg <= idx_reg - IDX_W'(1);
                            out_seq <= pattern_reg[idx_reg - IDX_W'(1)];
                        end else begin
                            rep_reg <= rep_reg - REP_W'(1);
                            if (rep_reg == REP_W'(1)) begin
                                state_reg <= IDLE;
                                out_seq   <= 1'b0;
                                out_valid <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end else if (gap_reg != '0) begin
                                state_reg   <= GAP;
                                gap_cnt_reg <= gap_reg;
                                out_seq     <= filler_bit;
                            end else begin
                                idx_reg     <= IDX_MSB;
                                out_seq     <= pattern_reg[PAT_W-1];
                                frame_start <= 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt_reg != GAP_W'(1)) begin
                            gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
                            out_seq     <= filler_bit;
                        end else begin
                            state_reg   <= SEND;
                            idx_reg     <= IDX_MSB;
                            out_seq     <= pattern_reg[PAT_W-1];
                            frame_start <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        out_seq   <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
